// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and sizing helper for the systolic skew feeder.
package SystolicTypes;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2,
    DONE = 2'd3
  } feeder_state_t;

  // Index width that never collapses to zero bits for tiny arrays.
  function automatic int clog2_min1(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_tile_buffer.sv
// N x N tile register file: one row/col write port, one read port per column.
module skew_tile_buffer
  import SystolicTypes::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int RW    = clog2_min1(N)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [RW-1:0]           wr_row,
  input  logic [RW-1:0]           wr_col,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [N-1:0][RW-1:0]    rd_row,
  output logic [N-1:0][WIDTH-1:0] rd_data
);

  // Contents are never cleared; the controller only reads a freshly completed tile.
  logic [WIDTH-1:0] mem_q [N][N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_row][wr_col] <= wr_data;
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      rd_data[j] = mem_q[rd_row[j]][j];
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads an n x n tile row-major, then feeds it diagonally skewed to a systolic array top edge.
// Build option SKEW_FEEDER_TRANSPOSE_EN adds a transpose input that stores the tile transposed.
module systolic_skew_feeder
  import SystolicTypes::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              n,
`ifdef SKEW_FEEDER_TRANSPOSE_EN
  input  logic                    transpose,
`endif
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    in_ready,
  input  logic                    feed_en,
  output logic [N-1:0][WIDTH-1:0] data_up,
  output logic [N-1:0]            valid_up,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int RW = clog2_min1(N);
  localparam int NW = clog2_min1(N + 1);
  localparam int TW = clog2_min1(2 * N);

  feeder_state_t state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [RW-1:0] row_q, row_d, col_q, col_d;
  logic [TW-1:0] t_q, t_d;
  logic          err_q, err_d;
  logic          beat;
  logic [RW-1:0] last_idx;
  logic [RW-1:0] wr_row, wr_col;
  logic [N-1:0][RW-1:0]    rd_row;
  logic [N-1:0][WIDTH-1:0] rd_data;
  logic [N-1:0]            col_vld;

  assign in_ready = (state_q == LOAD);
  assign beat     = in_valid && in_ready;
  assign last_idx = RW'(int'(n_q) - 1);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;

`ifdef SKEW_FEEDER_TRANSPOSE_EN
  logic tr_q, tr_d;
  assign wr_row = tr_q ? col_q : row_q;
  assign wr_col = tr_q ? row_q : col_q;
`else
  assign wr_row = row_q;
  assign wr_col = col_q;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    t_d     = t_q;
    err_d   = 1'b0;
`ifdef SKEW_FEEDER_TRANSPOSE_EN
    tr_d    = tr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (n == 4'd0) begin
            err_d = 1'b1;
          end else begin
            n_d     = (int'(n) > N) ? NW'(N) : NW'(n);
            row_d   = '0;
            col_d   = '0;
            t_d     = '0;
            state_d = LOAD;
`ifdef SKEW_FEEDER_TRANSPOSE_EN
            tr_d    = transpose;
`endif
          end
        end
      end
      LOAD: begin
        if (beat) begin
          if (col_q == last_idx) begin
            col_d = '0;
            if (row_q == last_idx) begin
              t_d     = '0;
              state_d = FEED;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FEED: begin
        if (feed_en) begin
          if (t_q == TW'(2 * int'(n_q) - 2)) begin
            state_d = DONE;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      t_q     <= '0;
      err_q   <= 1'b0;
`ifdef SKEW_FEEDER_TRANSPOSE_EN
      tr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      t_q     <= t_d;
      err_q   <= err_d;
`ifdef SKEW_FEEDER_TRANSPOSE_EN
      tr_q    <= tr_d;
`endif
    end
  end

  skew_tile_buffer #(
    .N     (N),
    .WIDTH (WIDTH),
    .RW    (RW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (beat),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (in_data),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  // Column j shows row t-j of its own column while that row index is inside the tile.
  always_comb begin
    rd_row  = '0;
    col_vld = '0;
    for (int j = 0; j < N; j++) begin
      if (state_q == FEED && j < int'(n_q) && int'(t_q) >= j && int'(t_q) - j < int'(n_q)) begin
        col_vld[j] = 1'b1;
        rd_row[j]  = RW'(int'(t_q) - j);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      data_up[j] = col_vld[j] ? rd_data[j] : '0;
    end
  end

  assign valid_up = col_vld;

endmodule
